// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial input and parallel word handshake bundle for sipo_deserializer
interface sipo_deserializer_if #(parameter int WIDTH = 4);
    logic                           sin;
    logic                           sin_valid;
    logic [WIDTH-1:0]               dout;
    logic                           dout_valid;
    logic                           dout_ready;
    logic [$clog2(WIDTH+1)-1:0]     bit_cnt;
    logic                           overflow;
    logic                           parity_err;

    modport master (
        output sin, sin_valid, dout_ready,
        input  dout, dout_valid, bit_cnt, overflow, parity_err
    );

    modport slave (
        input  sin, sin_valid, dout_ready,
        output dout, dout_valid, bit_cnt, overflow, parity_err
    );
endinterface

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: double-buffered serial-to-parallel word assembler; SIPO_PARITY_EN adds an even-parity bit per frame
module sipo_deserializer #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              reset,
    input logic              clear,
    sipo_deserializer_if.slave bus
);
`ifdef SIPO_PARITY_EN
    localparam int F = WIDTH + 1;
`else
    localparam int F = WIDTH;
`endif
    localparam int SW = F - 1;
    localparam int CW = $clog2(WIDTH + 1);

    logic [SW-1:0]    shreg;
    logic [F-1:0]     ext;
    logic [WIDTH-1:0] word;
    logic             done, good, take, free, load, ovf_set, perr_set;

    // frame completion, parity verdict and holding-register decisions for this edge
    always_comb begin
        ext      = {shreg, bus.sin};
        done     = bus.sin_valid && (bus.bit_cnt == CW'(F - 1));
`ifdef SIPO_PARITY_EN
        word     = ext[WIDTH:1];
        good     = ~^ext;
`else
        word     = ext;
        good     = 1'b1;
`endif
        take     = bus.dout_valid & bus.dout_ready;
        free     = ~bus.dout_valid | bus.dout_ready;
        load     = done & good & free;
        ovf_set  = done & good & ~free;
        perr_set = done & ~good;
    end

    // shift register, bit counter, holding register and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg          <= '0;
            bus.bit_cnt    <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.overflow   <= 1'b0;
            bus.parity_err <= 1'b0;
        end else if (clear) begin
            shreg          <= '0;
            bus.bit_cnt    <= '0;
            bus.dout_valid <= 1'b0;
            bus.overflow   <= 1'b0;
            bus.parity_err <= 1'b0;
        end else begin
            if (bus.sin_valid) begin
                shreg       <= ext[SW-1:0];
                bus.bit_cnt <= done ? '0 : bus.bit_cnt + CW'(1);
            end
            if (load)
                bus.dout <= word;
            bus.dout_valid <= load ? 1'b1 : take ? 1'b0 : bus.dout_valid;
            if (ovf_set)
                bus.overflow <= 1'b1;
            if (perr_set)
                bus.parity_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed plan plus random traffic checked against a frame-level reference model
module tb_sipo_deserializer;
    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int F = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int F = W;
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    int   total = 0;
    int   passed = 0;

    int         m_cnt, m_acc, m_dout;
    bit         m_dv, m_ovf, m_perr;
    logic [W-1:0] exp_w;

    sipo_deserializer_if #(.WIDTH(W)) bus ();

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cmp_all();
        chk("dout", 32'(bus.dout), 32'(m_dout));
        chk("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
        chk("bit_cnt", 32'(bus.bit_cnt), 32'(m_cnt));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
    endtask

    task automatic model_reset();
        m_cnt = 0; m_acc = 0; m_dout = 0; m_dv = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic model_edge(input bit s, input bit sv, input bit r, input bit c);
        bit loaded = 0;
        bit take = m_dv && r;
        int data;
        if (c) begin
            m_cnt = 0; m_acc = 0; m_dv = 0; m_ovf = 0; m_perr = 0;
            return;
        end
        if (sv) begin
            m_acc = m_acc * 2 + int'(s);
            m_cnt++;
            if (m_cnt == F) begin
                data = PAR ? m_acc / 2 : m_acc;
                if (PAR && ($countones(m_acc) % 2 != 0)) m_perr = 1;
                else if (!m_dv || r) begin m_dout = data; m_dv = 1; loaded = 1; end
                else m_ovf = 1;
                m_cnt = 0;
                m_acc = 0;
            end
        end
        if (take && !loaded) m_dv = 0;
    endtask

    task automatic step(input bit s, input bit sv, input bit r, input bit c);
        bus.sin = s; bus.sin_valid = sv; bus.dout_ready = r; clear = c;
        @(posedge clk);
        model_edge(s, sv, r, c);
        #1;
        cmp_all();
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit r, input bit r_last, input bit bad);
        for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, (i == 0 && !PAR) ? r_last : r, 1'b0);
        if (PAR) step((^w) ^ bad, 1'b1, r_last, 1'b0);
    endtask

    initial begin
        bus.sin = 0; bus.sin_valid = 0; bus.dout_ready = 0;
        model_reset();
        #2;
        cmp_all();
        @(posedge clk); #1;
        cmp_all();
        reset = 1'b0;

        send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
        exp_w = 4'b1011;
        chk("plan1_dout", 32'(bus.dout), 32'(exp_w));
        chk("plan1_valid", 32'(bus.dout_valid), 32'd1);

        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        if (PAR) step(1, 1, 0, 0);
        chk("gap_not_done", 32'(bus.dout_valid), 32'd0);
        step(1, 1, 0, 0);
        chk("gap_dout", 32'(bus.dout), 32'(exp_w));
        chk("gap_valid", 32'(bus.dout_valid), 32'd1);

        step(0, 0, 0, 1);
        send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b0, 1'b1, 1'b0);
        exp_w = 4'b0110;
        chk("b2b_dout", 32'(bus.dout), 32'(exp_w));
        chk("b2b_valid", 32'(bus.dout_valid), 32'd1);
        chk("b2b_ovf", 32'(bus.overflow), 32'd0);

        step(0, 0, 0, 1);
        send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0001, 1'b0, 1'b0, 1'b0);
        exp_w = 4'b1011;
        chk("ovf_dout", 32'(bus.dout), 32'(exp_w));
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        step(0, 0, 0, 1);
        chk("clr_ovf", 32'(bus.overflow), 32'd0);
        chk("clr_valid", 32'(bus.dout_valid), 32'd0);

        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        reset = 1'b1;
        #1;
        model_reset();
        cmp_all();
        #2;
        reset = 1'b0;
        send_frame(4'b1100, 1'b0, 1'b0, 1'b0);
        exp_w = 4'b1100;
        chk("rst_dout", 32'(bus.dout), 32'(exp_w));

        if (PAR) begin
            step(0, 0, 1, 0);
            send_frame(4'b0101, 1'b0, 1'b0, 1'b1);
            chk("perr_flag", 32'(bus.parity_err), 32'd1);
            chk("perr_no_ovf", 32'(bus.overflow), 32'd0);
        end

        for (int i = 0; i < 600; i++)
            step(1'($urandom), $urandom_range(3) != 0, 1'($urandom), $urandom_range(49) == 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
